x87_issue_ctrl: RTL and testbench

Issue controller between the ao486 front end and the x87 datapath. It buffers x87 instruction byte pairs in a small FIFO and presents the head entry to the x87 opcode decoder. It issues decoded commands to the x87 executor, with up to two commands in flight. It serializes status-reading and waiting instructions, and tracks pending unmasked FPU exceptions (#MF deferral).

---
 rtl/x87_issue_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_x87_issue_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x87_issue_ctrl.sv
// x87 issue controller: queues front-end opcode byte pairs, hands the FIFO head to the x87 decoder,
// serializes FWAIT/FNSTSW AX, defers unmasked FPU exceptions (#MF) and issues up to two commands.
// Latency: push in N -> head on dec_* in N+1 -> ex_valid in N+2; best case one issue every 2 cycles.
// Backpressure: in_ready drops when the FIFO holds QDEPTH entries; ex_valid/ex_cmd/ex_idx hold until ex_ready.
//
// Ports:
//   clk, rst                          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready, in_op1/in_op2/in_op2_valid   instruction push handshake and bytes
//   flush, clr_err                    front-end flush, pending-exception clear (FNCLEX)
//   dec_op1/dec_op2/dec_op2_valid     FIFO head, combinational to the decoder
//   dec_cmd/dec_cmd_valid/dec_idx     decoder result for the head (same cycle)
//   ex_valid/ex_ready, ex_cmd/ex_idx  issue handshake and command to the executor
//   ex_done/ex_err                    completion pulse, unmasked exception flag
//   ctrl_busy, ud_pulse, mf_pulse, to_pulse, fwait_done, err_pending   status

module x87_issue_ctrl #(
   parameter int QDEPTH       = 2,
   parameter int BUSY_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_op1,
   input  logic [7:0] in_op2,
   input  logic       in_op2_valid,
   input  logic       flush,
   input  logic       clr_err,
   output logic [7:0] dec_op1,
   output logic [7:0] dec_op2,
   output logic       dec_op2_valid,
   input  logic [4:0] dec_cmd,
   input  logic       dec_cmd_valid,
   input  logic [2:0] dec_idx,
   output logic       ex_valid,
   input  logic       ex_ready,
   output logic [4:0] ex_cmd,
   output logic [2:0] ex_idx,
   input  logic       ex_done,
   input  logic       ex_err,
   output logic       ctrl_busy,
   output logic       ud_pulse,
   output logic       mf_pulse,
   output logic       to_pulse,
   output logic       fwait_done,
   output logic       err_pending
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH + 1);

   localparam logic [4:0] CMD_NOP    = 5'd0;
   localparam logic [4:0] CMD_FNSTSW = 5'd1;
   localparam logic [4:0] CMD_FNINIT = 5'd2;
   localparam logic [4:0] CMD_FNSTCW = 5'd4;
   localparam logic [4:0] CMD_FWAIT  = 5'd5;

   typedef struct packed {
      logic [7:0] op1;
      logic [7:0] op2;
      logic       op2_vld;
   } entry_t;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

   entry_t          fifo_q [QDEPTH];
   entry_t          fifo_d [QDEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   state_t          state_q, state_d;
   logic [1:0]      outst_q, outst_d;
   logic [7:0]      wdog_q, wdog_d;
   logic [4:0]      ex_cmd_q, ex_cmd_d;
   logic [2:0]      ex_idx_q, ex_idx_d;
   logic            ud_q, ud_d;
   logic            mf_q, mf_d;
   logic            to_q, to_d;
   logic            fwd_q, fwd_d;
   logic            err_q, err_d;

   entry_t head;
   logic   fifo_empty, fifo_full;
   logic   push, pop, fifo_clr, mf_clr;
   logic   latch, fninit_clr;
   logic   issue_hs, done_eff, wdog_fire, err_set, drained;
   logic   is_nonwait, is_serial, is_wait;

   assign head       = fifo_q[rd_ptr_q];
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CW'(QDEPTH));

   // Command classes; FWAIT is serializing only, never "waiting".
   assign is_nonwait = (dec_cmd == CMD_NOP) || (dec_cmd == CMD_FNSTSW) ||
                       (dec_cmd == CMD_FNINIT) || (dec_cmd == CMD_FNSTCW);
   assign is_serial  = (dec_cmd == CMD_FWAIT) || (dec_cmd == CMD_FNSTSW);
   assign is_wait    = !is_nonwait && (dec_cmd != CMD_FWAIT);

   assign issue_hs = (state_q == ST_ISSUE) && ex_ready;
   // A completion with nothing outstanding is stale (e.g. from before a reset).
   assign done_eff = ex_done && (outst_q != 2'd0);
   assign drained  = (outst_q == 2'd0) || ((outst_q == 2'd1) && done_eff);

   // Watchdog: counts cycles with work outstanding and no completion.
   always_comb begin
      wdog_fire = 1'b0;
      if ((outst_q == 2'd0) || ex_done) begin
         wdog_d = '0;
      end else begin
         wdog_d = wdog_q + 8'd1;
         if (wdog_d == 8'(BUSY_TIMEOUT)) begin
            wdog_fire = 1'b1;
            wdog_d    = '0;
         end
      end
   end

   assign err_set = (done_eff && ex_err) || wdog_fire;

   // Issue FSM
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      mf_clr     = 1'b0;
      latch      = 1'b0;
      fninit_clr = 1'b0;
      ud_d       = 1'b0;
      mf_d       = 1'b0;
      fwd_d      = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  if (!dec_cmd_valid) begin
                     ud_d = 1'b1;
                     pop  = 1'b1;
                  end else if (is_wait && err_q) begin
                     // Deferred #MF: raise it and drop everything queued behind it.
                     mf_d   = 1'b1;
                     mf_clr = 1'b1;
                  end else if (is_serial) begin
                     state_d = ST_DRAIN;
                  end else if (outst_q != 2'd2) begin
                     latch      = 1'b1;
                     pop        = 1'b1;
                     state_d    = ST_ISSUE;
                     fninit_clr = (dec_cmd == CMD_FNINIT);
                  end
               end
            end
            ST_ISSUE: begin
               if (ex_ready) begin
                  state_d = ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) begin
                  state_d = ST_IDLE;
               end else if (drained) begin
                  if (dec_cmd == CMD_FWAIT) begin
                     // An error reported by the completion that finishes the drain counts too.
                     pop     = 1'b1;
                     mf_d    = err_q || err_set;
                     fwd_d   = !(err_q || err_set);
                     state_d = ST_IDLE;
                  end else if (dec_cmd == CMD_FNSTSW) begin
                     latch   = 1'b1;
                     pop     = 1'b1;
                     state_d = ST_ISSUE;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FIFO storage and pointers
   assign fifo_clr = flush || mf_clr;
   assign push     = in_valid && !fifo_full && !fifo_clr;

   always_comb begin
      fifo_d = fifo_q;
      if (push) begin
         fifo_d[wr_ptr_q] = '{op1: in_op1, op2: in_op2, op2_vld: in_op2_valid};
      end
      if (fifo_clr) begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = wr_ptr_q;
         cnt_d    = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + PW'(push);
         rd_ptr_d = rd_ptr_q + PW'(pop);
         cnt_d    = cnt_q + CW'(push) - CW'(pop);
      end
   end

   // Outstanding counter, exception flag and issue register
   always_comb begin
      outst_d = outst_q;
      if (wdog_fire) begin
         outst_d = 2'd0;
      end else if (issue_hs && !done_eff) begin
         outst_d = (outst_q == 2'd2) ? 2'd2 : outst_q + 2'd1;
      end else if (!issue_hs && done_eff) begin
         outst_d = outst_q - 2'd1;
      end

      // Set has priority over clear.
      if (err_set) begin
         err_d = 1'b1;
      end else if (clr_err || fninit_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end

      ex_cmd_d = latch ? dec_cmd : ex_cmd_q;
      ex_idx_d = latch ? dec_idx : ex_idx_q;
      to_d     = wdog_fire;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < QDEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         state_q  <= ST_IDLE;
         outst_q  <= '0;
         wdog_q   <= '0;
         ex_cmd_q <= '0;
         ex_idx_q <= '0;
         ud_q     <= 1'b0;
         mf_q     <= 1'b0;
         to_q     <= 1'b0;
         fwd_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            fifo_q[i] <= fifo_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         outst_q  <= outst_d;
         wdog_q   <= wdog_d;
         ex_cmd_q <= ex_cmd_d;
         ex_idx_q <= ex_idx_d;
         ud_q     <= ud_d;
         mf_q     <= mf_d;
         to_q     <= to_d;
         fwd_q    <= fwd_d;
         err_q    <= err_d;
      end
   end

   assign in_ready      = !fifo_full;
   assign dec_op1       = head.op1;
   assign dec_op2       = head.op2;
   assign dec_op2_valid = head.op2_vld;
   assign ex_valid      = (state_q == ST_ISSUE);
   assign ex_cmd        = ex_cmd_q;
   assign ex_idx        = ex_idx_q;
   assign ctrl_busy     = !fifo_empty || (state_q != ST_IDLE) || (outst_q != 2'd0);
   assign ud_pulse      = ud_q;
   assign mf_pulse      = mf_q;
   assign to_pulse      = to_q;
   assign fwait_done    = fwd_q;
   assign err_pending   = err_q;

endmodule

// File: tb/tb_x87_issue_ctrl.sv
// Directed bench for x87_issue_ctrl: cycle tables for issue/limit/FWAIT drain, hand sequences for the rest.
// A small opcode decoder model feeds dec_cmd/dec_idx back from the FIFO head.
// Outputs are sampled on the falling edge (tables) or 1 ns after the rising edge (sequences).

module tb_x87_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready;
   logic [7:0] in_op1, in_op2;
   logic       in_op2_valid, flush, clr_err;
   logic [7:0] dec_op1, dec_op2;
   logic       dec_op2_valid;
   logic [4:0] dec_cmd;
   logic       dec_cmd_valid;
   logic [2:0] dec_idx;
   logic       ex_valid, ex_ready;
   logic [4:0] ex_cmd;
   logic [2:0] ex_idx;
   logic       ex_done, ex_err;
   logic       ctrl_busy, ud_pulse, mf_pulse, to_pulse, fwait_done, err_pending;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   x87_issue_ctrl #(.QDEPTH(2), .BUSY_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op1(in_op1), .in_op2(in_op2), .in_op2_valid(in_op2_valid),
      .flush(flush), .clr_err(clr_err),
      .dec_op1(dec_op1), .dec_op2(dec_op2), .dec_op2_valid(dec_op2_valid),
      .dec_cmd(dec_cmd), .dec_cmd_valid(dec_cmd_valid), .dec_idx(dec_idx),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_cmd(ex_cmd), .ex_idx(ex_idx),
      .ex_done(ex_done), .ex_err(ex_err),
      .ctrl_busy(ctrl_busy), .ud_pulse(ud_pulse), .mf_pulse(mf_pulse),
      .to_pulse(to_pulse), .fwait_done(fwait_done), .err_pending(err_pending)
   );

   // Decoder model: 9B=FWAIT(5), DB E3=FNINIT(2), DF E0=FNSTSW AX(1), D9 Cx=10, D8 xx=11, DE xx=13.
   always_comb begin
      dec_cmd       = 5'd0;
      dec_cmd_valid = 1'b0;
      dec_idx       = 3'd0;
      case (dec_op1)
         8'h9B: begin dec_cmd = 5'd5; dec_cmd_valid = 1'b1; end
         8'hD8: begin dec_cmd = 5'd11; dec_cmd_valid = 1'b1; dec_idx = dec_op2[2:0]; end
         8'hD9: begin dec_cmd = 5'd10; dec_cmd_valid = 1'b1; dec_idx = dec_op2[2:0]; end
         8'hDE: begin dec_cmd = 5'd13; dec_cmd_valid = 1'b1; dec_idx = dec_op2[2:0]; end
         8'hDB: if (dec_op2_valid && dec_op2 == 8'hE3) begin dec_cmd = 5'd2; dec_cmd_valid = 1'b1; end
         8'hDF: if (dec_op2_valid && dec_op2 == 8'hE0) begin dec_cmd = 5'd1; dec_cmd_valid = 1'b1; end
         default: ;
      endcase
   end

   typedef struct {
      logic       iv;
      logic [7:0] o1;
      logic [7:0] o2;
      logic       o2v;
      logic       rdy;
      logic       done;
      logic       ev;
      logic [4:0] cmd;
      logic [2:0] idx;
      logic       busy;
      logic       irdy;
      logic [3:0] pls;   // {ud, mf, to, fwait_done}
      logic       errp;
   } vec_t;

   vec_t tbl[$];

   task automatic row(input logic iv, input logic [7:0] o1, input logic [7:0] o2, input logic o2v,
                      input logic rdy, input logic done, input logic ev, input logic [4:0] cmd,
                      input logic [2:0] idx, input logic busy, input logic irdy,
                      input logic [3:0] pls, input logic errp);
      vec_t v;
      v.iv = iv; v.o1 = o1; v.o2 = o2; v.o2v = o2v; v.rdy = rdy; v.done = done;
      v.ev = ev; v.cmd = cmd; v.idx = idx; v.busy = busy; v.irdy = irdy; v.pls = pls; v.errp = errp;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [7:0] o1, input logic [7:0] o2, input logic o2v);
      in_valid = 1'b1; in_op1 = o1; in_op2 = o2; in_op2_valid = o2v;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [15:0] got, want;

      rst = 1'b1; in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_op2_valid = 1'b0;
      flush = 1'b0; clr_err = 1'b0; ex_ready = 1'b0; ex_done = 1'b0; ex_err = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_cmd", {ex_cmd, ex_idx}, 0);
      chk("rst_busy", ctrl_busy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_pulses", {ud_pulse, mf_pulse, to_pulse, fwait_done}, 0);
      chk("rst_err", err_pending, 0);

      // Push D9 C1 -> issue cmd 10 idx 1, then completion
      row(1, 8'hD9, 8'hC1, 1, 1, 0,  0, 0, 0,  0, 1, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 0,  0, 0, 0,  1, 1, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 0,  1, 10, 1, 1, 1, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 1,  0, 0, 0,  1, 1, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 0,  0, 0, 0,  0, 1, 4'b0000, 0);
      // Issue limit of two, then FWAIT drain without executor issue
      row(1, 8'hD8, 8'hC0, 1, 1, 0,  0, 0, 0,  0, 1, 4'b0000, 0);
      row(1, 8'hDE, 8'hC9, 1, 1, 0,  0, 0, 0,  1, 1, 4'b0000, 0);
      row(1, 8'hD8, 8'hF1, 1, 1, 0,  1, 11, 0, 1, 1, 4'b0000, 0);
      row(1, 8'h9B, 8'h00, 0, 1, 0,  0, 0, 0,  1, 0, 4'b0000, 0);
      row(1, 8'h9B, 8'h00, 0, 1, 0,  1, 13, 1, 1, 1, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 0,  0, 0, 0,  1, 0, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 0,  0, 0, 0,  1, 0, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 1,  0, 0, 0,  1, 0, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 0,  0, 0, 0,  1, 0, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 0,  1, 11, 1, 1, 1, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 0,  0, 0, 0,  1, 1, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 0,  0, 0, 0,  1, 1, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 1,  0, 0, 0,  1, 1, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 1,  0, 0, 0,  1, 1, 4'b0000, 0);
      row(0, 8'h00, 8'h00, 0, 1, 0,  0, 0, 0,  0, 1, 4'b0001, 0);
      row(0, 8'h00, 8'h00, 0, 1, 0,  0, 0, 0,  0, 1, 4'b0000, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         in_valid = tbl[i].iv; in_op1 = tbl[i].o1; in_op2 = tbl[i].o2; in_op2_valid = tbl[i].o2v;
         ex_ready = tbl[i].rdy; ex_done = tbl[i].done;
         @(negedge clk);
         want = {tbl[i].ev, tbl[i].ev ? tbl[i].cmd : 5'd0, tbl[i].ev ? tbl[i].idx : 3'd0,
                 tbl[i].busy, tbl[i].irdy, tbl[i].pls, tbl[i].errp};
         got  = {ex_valid, tbl[i].ev ? ex_cmd : 5'd0, tbl[i].ev ? ex_idx : 3'd0,
                 ctrl_busy, in_ready, ud_pulse, mf_pulse, to_pulse, fwait_done, err_pending};
         chk($sformatf("row%0d", i), got, want);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; ex_done = 1'b0; ex_ready = 1'b1;

      // Deferred #MF
      push1(8'hD9, 8'hC1, 1);
      tick();
      chk("mf_first_issue", ex_valid, 1);
      tick();
      ex_done = 1'b1; ex_err = 1'b1;
      tick();
      ex_done = 1'b0; ex_err = 1'b0;
      chk("mf_err_set", err_pending, 1);
      push1(8'hD8, 8'hC1, 1);
      tick();
      chk("mf_pulse_a", mf_pulse, 1);
      chk("mf_fifo_empty_a", ctrl_busy, 0);
      chk("mf_no_issue_a", ex_valid, 0);
      chk("mf_err_kept_a", err_pending, 1);
      tick();
      chk("mf_pulse_width", mf_pulse, 0);
      push1(8'hD9, 8'hC2, 1);
      tick();
      chk("mf_pulse_b", mf_pulse, 1);
      chk("mf_err_kept_b", err_pending, 1);
      push1(8'hDB, 8'hE3, 1);
      tick();
      chk("fninit_valid", ex_valid, 1);
      chk("fninit_cmd", ex_cmd, 2);
      chk("fninit_err_clr", err_pending, 0);
      tick();
      ex_done = 1'b1;
      tick();
      ex_done = 1'b0;
      chk("fninit_done_idle", ctrl_busy, 0);

      // Undecodable opcode
      push1(8'hDA, 8'hC0, 1);
      tick();
      chk("ud_pulse", ud_pulse, 1);
      chk("ud_no_issue", ex_valid, 0);
      chk("ud_popped", ctrl_busy, 0);
      tick();
      chk("ud_pulse_width", ud_pulse, 0);

      // FNSTSW AX: drains then issues cmd 1
      push1(8'hDF, 8'hE0, 1);
      tick();
      tick();
      chk("fnstsw_issue", {ex_valid, ex_cmd}, {1'b1, 5'd1});
      tick();
      ex_done = 1'b1;
      tick();
      ex_done = 1'b0;

      // One command outstanding, then fill the FIFO with the executor stalled
      push1(8'hD9, 8'hC3, 1);
      tick();
      tick();
      ex_ready = 1'b0;
      in_valid = 1'b1; in_op1 = 8'hD9; in_op2 = 8'hC4; in_op2_valid = 1'b1;
      tick();
      in_op2 = 8'hC5;
      tick();
      chk("fill_issue_hold", {ex_valid, ex_cmd, ex_idx}, {1'b1, 5'd10, 3'd4});
      chk("fill_ready_one", in_ready, 1);
      in_op2 = 8'hC6;
      tick();
      chk("fill_full", in_ready, 0);
      tick();
      chk("fill_still_full", in_ready, 0);
      in_valid = 1'b0;

      // Flush while ex_valid is held
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_drop_valid", ex_valid, 0);
      chk("flush_fifo_empty", in_ready, 1);
      chk("flush_outst_kept", ctrl_busy, 1);
      tick();
      chk("flush_no_reissue", ex_valid, 0);
      ex_done = 1'b1;
      tick();
      ex_done = 1'b0;
      chk("flush_done_idle", ctrl_busy, 0);

      // Flush coincident with a push
      in_valid = 1'b1; in_op1 = 8'hD9; in_op2 = 8'hC7; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_push_dropped", ctrl_busy, 0);
      tick();
      tick();
      chk("flush_push_no_issue", {ex_valid, ctrl_busy}, 0);

      // Watchdog
      ex_ready = 1'b1;
      push1(8'hD9, 8'hC1, 1);
      tick();
      tick();
      n = 0;
      while (n < 300 && !to_pulse) begin
         tick();
         n++;
      end
      chk("wd_cycles", n, 255);
      chk("wd_outst_zero", ctrl_busy, 0);
      chk("wd_err_set", err_pending, 1);
      tick();
      chk("wd_pulse_width", to_pulse, 0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_err", err_pending, 0);

      // Set beats clear in the same cycle
      push1(8'hD9, 8'hC1, 1);
      tick();
      tick();
      ex_done = 1'b1; ex_err = 1'b1; clr_err = 1'b1;
      tick();
      ex_done = 1'b0; ex_err = 1'b0; clr_err = 1'b0;
      chk("set_wins", err_pending, 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;

      // Reset mid-operation; late completion is ignored
      push1(8'hD9, 8'hC1, 1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_idle", {ctrl_busy, err_pending}, 0);
      ex_done = 1'b1;
      tick();
      ex_done = 1'b0;
      push1(8'hD9, 8'hC1, 1);
      tick();
      tick();
      chk("post_rst_outst_one", ctrl_busy, 1);
      ex_done = 1'b1;
      tick();
      ex_done = 1'b0;
      chk("post_rst_outst_zero", ctrl_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
